gpi_irq: RTL and testbench
==========================

# gpi_irq

Parametrised general-purpose input block with per-channel synchronisation, debounce filtering, edge detection and a level interrupt output. It sits on the 5-bit CSR bus next to the other CPLD peripherals. It exposes four 8-bit registers: input state, interrupt enable, interrupt pending and edge select. It drives one interrupt line to the CPLD interrupt aggregator.

## Interface
- BASE_ADDR, 5'h0, address of register 0. Must be a multiple of 4; the block decodes BASE_ADDR..BASE_ADDR+3.
- NUM_GPIOS, 8, number of input channels, 1..8.
- DEBOUNCE, 4, number of consecutive clocks a changed synchronised input must be stable before it is accepted, 1..255.
- clk  input  1  clock.
- rst  input  1  reset: synchronous, active-high.
- csr_a  input  5  CSR register address.
- csr_di  input  8  CSR write data.
- csr_we  input  1  CSR write strobe, one clk per write.
- csr_do  output  8  CSR read data, combinational from csr_a.
- in  input  NUM_GPIOS  asynchronous pin inputs.
- irq  output  1  interrupt, high while any enabled pending bit is set.

## Operation
- Per channel, two-flop synchroniser: s0 <= in, s1 <= s0.
- Per channel debounce uses a state bit deb and a counter cnt of width ceil(log2(DEBOUNCE+1)).
  - If s1 == deb: cnt <= 0.
  - Else if cnt == DEBOUNCE-1: deb <= s1 and cnt <= 0 (this is the accept event).
  - Else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE clocks never reaches deb, and restarts the count from 0.
- Edge detection:
  - An accept event with s1 == 1 is a rising edge; with s1 == 0 it is a falling edge.
  - IP[i] is set at the accept edge when the edge matches IEV[i]: 1 = rising, 0 = falling.
  - IP bits set regardless of IE.
- Registers (offset from BASE_ADDR); bits at or above NUM_GPIOS read 0 and ignore writes:
  - +0 IN: read-only, reads deb. Writes are ignored.
  - +1 IE: read/write interrupt enable.
  - +2 IP: read returns pending bits. Writing 1 to a bit clears it; writing 0 has no effect.
  - +3 IEV: read/write edge select.
- When one edge both sets and W1C-clears the same IP bit, the set wins and the bit stays 1.
- irq = |(IP & IE), combinational from registers. Changing IE takes effect immediately on irq.
- csr_do = 0 when csr_a is outside BASE_ADDR..BASE_ADDR+3.
- Reset values: s0, s1, deb, cnt, IE, IP and IEV are all 0; therefore irq = 0.
- Pins high at reset release: deb rises after the normal latency. No IP is set because IEV resets to 0 (falling edge).
- rst asserted mid-debounce discards the partial count; no IP is set.

## Timing
- A change on `in` captured at edge N lands in s1 at edge N+1.
- If the value stays stable, deb and IP update at edge N+1+DEBOUNCE.
- irq rises combinationally after that same edge.
- CSR reads are zero-wait: csr_do is valid in the same cycle as csr_a.
- CSR writes take effect at the clk edge where csr_we = 1. A read of the register in the following cycle returns the new value.
- W1C clears IP at the write edge, so irq falls in the next cycle unless the set-wins rule applies.

## Test plan
- Reset → reads at +0..+3 all return 0x00; irq = 0. Read at BASE_ADDR+4 → 0x00.
- DEBOUNCE=4, in[0] 0→1 captured at edge N and held → IN reads 0x00 through edge N+4 and 0x01 after edge N+5.
- Debounce filtering (DEBOUNCE=4):
  - in[2] pulses high for 3 clocks → IN stays 0x00 and IP stays 0x00.
  - in[2] pulses high for 4 clocks → IN bit 2 goes to 1.
- Edge select and enable: IEV=0x01, IE=0x01, in[0] rises → IP=0x01, irq=1. Write 0x01 to +2 → IP=0x00, irq=0. A later fall of in[0] sets no IP.
- Collision: W1C of IP bit 3 on the same edge as a matching accept on channel 3 → IP bit 3 reads 1 afterwards.
- NUM_GPIOS=3, BASE_ADDR=5'h8: write 0xFF to +1 (addr 0x09) → reads 0x07. Writes to addresses 0x00 and 0x0C have no effect.

Source files
------------

// File: rtl/gpi_irq.sv
// General-purpose input block: per-channel two-flop sync, debounce and edge detection,
// with IN/IE/IP/IEV registers on the 5-bit CSR bus and a level interrupt output.
module gpi_irq #(
    parameter logic [4:0] BASE_ADDR = 5'h0,
    parameter int         NUM_GPIOS = 8,
    parameter int         DEBOUNCE  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           csr_a,
    input  logic [7:0]           csr_di,
    input  logic                 csr_we,
    output logic [7:0]           csr_do,
    input  logic [NUM_GPIOS-1:0] in,
    output logic                 irq
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [NUM_GPIOS-1:0] s1_vec;
    logic [NUM_GPIOS-1:0] deb_vec;
    logic [NUM_GPIOS-1:0] acc_vec;

    generate
        for (genvar gi = 0; gi < NUM_GPIOS; gi++) begin : g_ch
            logic          s0_q, s0_d;
            logic          s1_q, s1_d;
            logic          deb_q, deb_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          acc;

            // Any disagreement shorter than DEBOUNCE clocks restarts the count.
            always_comb begin
                s0_d  = in[gi];
                s1_d  = s0_q;
                deb_d = deb_q;
                cnt_d = cnt_q;
                acc   = 1'b0;
                if (s1_q == deb_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    deb_d = s1_q;
                    cnt_d = '0;
                    acc   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s0_q  <= 1'b0;
                    s1_q  <= 1'b0;
                    deb_q <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    s0_q  <= s0_d;
                    s1_q  <= s1_d;
                    deb_q <= deb_d;
                    cnt_q <= cnt_d;
                end
            end

            assign s1_vec[gi]  = s1_q;
            assign deb_vec[gi] = deb_q;
            assign acc_vec[gi] = acc;
        end
    endgenerate

    logic [NUM_GPIOS-1:0] ie_q, ie_d;
    logic [NUM_GPIOS-1:0] ip_q, ip_d;
    logic [NUM_GPIOS-1:0] iev_q, iev_d;
    logic [NUM_GPIOS-1:0] wdata;
    logic [NUM_GPIOS-1:0] edge_set;
    logic                 csr_hit;

    assign csr_hit  = (csr_a[4:2] == BASE_ADDR[4:2]);
    assign wdata    = csr_di[NUM_GPIOS-1:0];
    // An accepted value equal to the IEV bit is exactly the selected edge.
    assign edge_set = acc_vec & ~(s1_vec ^ iev_q);

    always_comb begin
        ie_d  = ie_q;
        iev_d = iev_q;
        ip_d  = ip_q;
        if (csr_we && csr_hit) begin
            case (csr_a[1:0])
                2'd1:    ie_d  = wdata;
                2'd2:    ip_d  = ip_q & ~wdata;
                2'd3:    iev_d = wdata;
                default: ;
            endcase
        end
        // Applied after the W1C so a simultaneous set wins.
        ip_d = ip_d | edge_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q  <= '0;
            ip_q  <= '0;
            iev_q <= '0;
        end else begin
            ie_q  <= ie_d;
            ip_q  <= ip_d;
            iev_q <= iev_d;
        end
    end

    always_comb begin
        csr_do = 8'h00;
        if (csr_hit) begin
            case (csr_a[1:0])
                2'd0:    csr_do = 8'(deb_vec);
                2'd1:    csr_do = 8'(ie_q);
                2'd2:    csr_do = 8'(ip_q);
                default: csr_do = 8'(iev_q);
            endcase
        end
    end

    assign irq = |(ip_q & ie_q);

endmodule

// File: tb/tb_gpi_irq.sv
// Bench for gpi_irq: directed vector tables, hand sequences for debounce/W1C corners,
// and a randomized phase checked against a sample-history reference model.
module tb_gpi_irq;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] csr_a = '0;
    logic [7:0] csr_di = '0;
    logic       csr_we = 1'b0;
    logic [7:0] csr_do;
    logic [7:0] in_r = '0;
    logic       irq;

    logic [4:0] csr2_a = '0;
    logic [7:0] csr2_di = '0;
    logic       csr2_we = 1'b0;
    logic [7:0] csr2_do;
    logic [2:0] in2 = '0;
    logic       irq2;

    always #5 clk = ~clk;

    gpi_irq #(.BASE_ADDR(5'h0), .NUM_GPIOS(8), .DEBOUNCE(DEB)) dut (
        .clk(clk), .rst(rst), .csr_a(csr_a), .csr_di(csr_di), .csr_we(csr_we),
        .csr_do(csr_do), .in(in_r), .irq(irq)
    );

    gpi_irq #(.BASE_ADDR(5'h8), .NUM_GPIOS(3), .DEBOUNCE(DEB)) dut2 (
        .clk(clk), .rst(rst), .csr_a(csr2_a), .csr_di(csr2_di), .csr_we(csr2_we),
        .csr_do(csr2_do), .in(in2), .irq(irq2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, got, exp);
        end
    endtask

    // Reference model: a value is accepted once the last DEB synchronised samples
    // all disagree with the accepted value.
    logic [7:0]   m_s0 = '0, m_s1 = '0, m_deb = '0, m_ie = '0, m_ip = '0, m_iev = '0;
    logic [255:0] m_hist [8];
    logic [255:0] m_mask;
    logic [7:0]   m_set, m_deb_n, m_w1c;

    task automatic model_step();
        m_mask = (256'(1) << DEB) - 256'(1);
        if (rst) begin
            m_s0 = '0; m_s1 = '0; m_deb = '0; m_ie = '0; m_ip = '0; m_iev = '0;
            for (int i = 0; i < 8; i++) m_hist[i] = '0;
        end else begin
            m_set = '0;
            m_deb_n = m_deb;
            m_w1c = '0;
            for (int i = 0; i < 8; i++) begin
                m_hist[i] = {m_hist[i][254:0], m_s1[i]};
                if ((m_hist[i] & m_mask) == (m_deb[i] ? 256'(0) : m_mask)) begin
                    m_deb_n[i] = m_s1[i];
                    if (m_s1[i] == m_iev[i]) m_set[i] = 1'b1;
                end
            end
            if (csr_we && csr_a < 5'd4) begin
                if (csr_a == 5'd1) m_ie = csr_di;
                if (csr_a == 5'd2) m_w1c = csr_di;
                if (csr_a == 5'd3) m_iev = csr_di;
            end
            m_ip  = (m_ip & ~m_w1c) | m_set;
            m_deb = m_deb_n;
            m_s1  = m_s0;
            m_s0  = in_r;
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [4:0] a);
        case (a)
            5'd0:    return m_deb;
            5'd1:    return m_ie;
            5'd2:    return m_ip;
            5'd3:    return m_iev;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) m_hist[i] = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    typedef struct {
        logic [4:0] a;
        logic       we;
        logic [7:0] di;
        logic [7:0] exp_do;
        logic       exp_irq;
    } vec_t;

    vec_t tbl1 [6];
    vec_t tbl2 [11];

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        csr_a = a; csr_di = d; csr_we = 1'b1;
        @(negedge clk);
        csr_we = 1'b0;
        $display("write addr 0x%02h data 0x%02h", a, d);
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [7:0] exp);
        csr_a = a;
        #1;
        check(name, csr_do, exp);
        $display("read addr 0x%02h -> 0x%02h", a, csr_do);
    endtask

    int seen;

    initial begin
        tbl1[0] = '{5'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl1[1] = '{5'h01, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl1[2] = '{5'h02, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl1[3] = '{5'h03, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl1[4] = '{5'h04, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl1[5] = '{5'h1F, 1'b0, 8'h00, 8'h00, 1'b0};

        tbl2[0]  = '{5'h08, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl2[1]  = '{5'h09, 1'b1, 8'hFF, 8'h00, 1'b0};
        tbl2[2]  = '{5'h09, 1'b0, 8'h00, 8'h07, 1'b0};
        tbl2[3]  = '{5'h00, 1'b1, 8'hFF, 8'h00, 1'b0};
        tbl2[4]  = '{5'h0C, 1'b1, 8'hFF, 8'h00, 1'b0};
        tbl2[5]  = '{5'h0B, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl2[6]  = '{5'h0A, 1'b0, 8'h00, 8'h00, 1'b0};
        tbl2[7]  = '{5'h0B, 1'b1, 8'h05, 8'h00, 1'b0};
        tbl2[8]  = '{5'h0B, 1'b0, 8'h00, 8'h05, 1'b0};
        tbl2[9]  = '{5'h09, 1'b0, 8'h00, 8'h07, 1'b0};
        tbl2[10] = '{5'h0C, 1'b0, 8'h00, 8'h00, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            csr_a = tbl1[i].a; csr_di = tbl1[i].di; csr_we = tbl1[i].we;
            #1;
            check("reset_rd", csr_do, tbl1[i].exp_do);
            check("reset_irq", 8'(irq), 8'(tbl1[i].exp_irq));
            $display("vec1 %0d addr 0x%02h -> 0x%02h irq %0b", i, tbl1[i].a, csr_do, irq);
        end
        @(negedge clk);
        csr_we = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            csr2_a = tbl2[i].a; csr2_di = tbl2[i].di; csr2_we = tbl2[i].we;
            #1;
            check("n3_rd", csr2_do, tbl2[i].exp_do);
            check("n3_irq", 8'(irq2), 8'(tbl2[i].exp_irq));
            $display("vec2 %0d addr 0x%02h we %0b -> 0x%02h", i, tbl2[i].a, tbl2[i].we, csr2_do);
        end
        @(negedge clk);
        csr2_we = 1'b0;

        // Rising edge on ch0 with IEV/IE set: latency and irq timing.
        wr(5'd3, 8'h01);
        wr(5'd1, 8'h01);
        in_r[0] = 1'b1;
        csr_a = 5'd0;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            check("latency_in", csr_do, (k == 5) ? 8'h01 : 8'h00);
            check("latency_irq", 8'(irq), (k == 5) ? 8'h01 : 8'h00);
        end
        rd_chk("ip_rise", 5'd2, 8'h01);
        wr(5'd2, 8'h01);
        rd_chk("ip_w1c", 5'd2, 8'h00);
        check("irq_w1c", 8'(irq), 8'h00);

        in_r[0] = 1'b0;
        repeat (10) @(negedge clk);
        rd_chk("fall_in", 5'd0, 8'h00);
        rd_chk("fall_ip", 5'd2, 8'h00);
        check("fall_irq", 8'(irq), 8'h00);

        // 3-clock glitch on ch2 must be filtered out.
        @(negedge clk);
        in_r[2] = 1'b1;
        repeat (3) @(negedge clk);
        in_r[2] = 1'b0;
        seen = 0;
        csr_a = 5'd0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (csr_do[2]) seen = 1;
        end
        check("glitch3_in", 8'(seen), 8'h00);
        rd_chk("glitch3_ip", 5'd2, 8'h00);

        // 4-clock pulse is accepted; its accepted fall sets IP2 even with IE2 off.
        in_r[2] = 1'b1;
        repeat (4) @(negedge clk);
        in_r[2] = 1'b0;
        seen = 0;
        csr_a = 5'd0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (csr_do[2]) seen = 1;
        end
        check("pulse4_in", 8'(seen), 8'h01);
        rd_chk("pulse4_ip", 5'd2, 8'h04);
        check("pulse4_irq", 8'(irq), 8'h00);
        wr(5'd1, 8'h05);
        check("ie_immediate_irq", 8'(irq), 8'h01);
        wr(5'd2, 8'h04);
        check("ie_w1c_irq", 8'(irq), 8'h00);

        // W1C of IP3 on the same edge as a matching accept on ch3.
        wr(5'd3, 8'h08);
        in_r[3] = 1'b1;
        repeat (5) @(negedge clk);
        rd_chk("collide_pre", 5'd2, 8'h00);
        csr_di = 8'h08; csr_we = 1'b1;
        @(negedge clk);
        csr_we = 1'b0;
        rd_chk("collide_post", 5'd2, 8'h08);
        wr(5'd2, 8'h08);
        rd_chk("collide_clear", 5'd2, 8'h00);

        // Reset in the middle of a debounce count.
        in_r[5] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        csr_a = 5'd0;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            check("rst_mid_in5", 8'(csr_do[5]), (k == 5) ? 8'h01 : 8'h00);
        end
        rd_chk("rst_mid_ip", 5'd2, 8'h00);
        rd_chk("rst_mid_ie", 5'd1, 8'h00);

        // Randomized phase against the reference model.
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            check("rand_do", csr_do, model_rd(csr_a));
            check("rand_irq", 8'(irq), 8'(|(m_ip & m_ie)));
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 9) == 0) in_r[i] = ~in_r[i];
            csr_a  = ($urandom_range(0, 15) == 0) ? 5'h1F : 5'($urandom_range(0, 7));
            csr_we = ($urandom_range(0, 3) == 0);
            csr_di = 8'($urandom);
            if (csr_we) $display("rand write addr 0x%02h data 0x%02h", csr_a, csr_di);
        end
        @(negedge clk);
        csr_we = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
